tmng_engine: RTL and testbench
==============================

TMNG_ENGINE -- requirements
Module: tmng_engine

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each register word and of the operands.
REQ-002 Parameter ADDR_W, default 7, register address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  engine can accept a command this cycle.
REQ-007 cmd_op  input  3  opcode: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOTA, 7 LOAD.
REQ-008 cmd_a  input  ADDR_W  first operand address.
REQ-009 cmd_b  input  ADDR_W  second operand address; ignored for NOTA and LOAD.
REQ-010 cmd_d  input  ADDR_W  destination address.
REQ-011 cmd_imm  input  WIDTH  immediate value; used only by LOAD.
REQ-012 res_valid  output  1  one-cycle pulse: result written.
REQ-013 res_data  output  WIDTH  value written by the most recent command.
REQ-014 busy  output  1  engine is not in IDLE.
REQ-015 op_count  output  16  count of completed commands, saturating.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RD_A, RD_B, EX and WB.
REQ-017 cmd_ready SHALL be 1 only in IDLE; busy SHALL equal the inverse of cmd_ready.
REQ-018 The engine SHALL accept a command on a cycle with cmd_valid=1 and cmd_ready=1, latching cmd_op, cmd_a, cmd_b, cmd_d and cmd_imm.
REQ-019 On accept, the next state SHALL be WB for LOAD and RD_A for all other opcodes.
REQ-020 The read port has 1-cycle latency: the address is issued in one cycle and the data is registered at the next edge.
REQ-021 RD_A SHALL issue address a. RD_B SHALL issue address b and capture opa. EX SHALL capture opb and compute the result.
REQ-022 For NOTA, the FSM SHALL still pass through RD_B; opb is don't-care.
REQ-023 Results are bitwise over WIDTH bits. NOTA = ~opa. LOAD = cmd_imm.
REQ-024 In WB the engine SHALL write the result to address d, set res_data to the result, pulse res_valid=1 and return to IDLE.
REQ-025 Latency from the accept edge to res_valid SHALL be 4 cycles for logic ops and 1 cycle for LOAD.
REQ-026 Maximum throughput SHALL be one command per 5 cycles for logic ops and one per 2 cycles for LOAD.
REQ-027 When d equals a or b, the operands SHALL be read before the write; the old value is used.
REQ-028 A write SHALL be visible to any read issued in a later command.
REQ-029 op_count SHALL increment on each res_valid and hold at 16'hFFFF.
REQ-030 cmd_valid outside IDLE SHALL have no effect; the command is not latched and the engine does not stall.
REQ-031 res_data SHALL hold its value between res_valid pulses.

Reset
REQ-032 While rst_n=0, the engine SHALL force: state=IDLE, res_valid=0, res_data=0, op_count=0 and all DEPTH words=0.
REQ-033 Assertion of rst_n=0 mid-command SHALL abort the command with no write and no res_valid.
REQ-034 cmd_ready SHALL be 1 from the first rising clock edge after rst_n deasserts.

Structure
REQ-035 Package tmng_pkg SHALL hold the opcode enum (NAND..LOAD) and the state enum (IDLE..WB).
REQ-036 Sub-module tmng_regfile SHALL provide DEPTH x WIDTH storage with one synchronous read port, one write port and asynchronous clear.
REQ-037 The opcode ALU SHALL be combinational logic inside tmng_engine.

Verification
REQ-038 Scenario: LOAD d=5 imm=1, then OR a=5 b=5 d=6 -> second res_valid with res_data=1, and r6=1.
REQ-039 Scenario: with r0=1, r1=1, issue NAND a=0 b=1 d=0 -> res_data=0 exactly 4 cycles after accept, then r0=0.
REQ-040 Scenario: WIDTH=4, r2=4'b1100, r3=4'b1010 -> XOR gives 4'b0110, XNOR gives 4'b1001, NOR gives 4'b0001.
REQ-041 Scenario: hold cmd_valid=1 continuously -> cmd_ready=0 in RD_A..WB, one command accepted per 5 cycles, no command lost or duplicated.
REQ-042 Scenario: rst_n=0 during RD_B of NAND a=0 b=1 d=7 -> no res_valid, r7=0, op_count=0, and cmd_ready=1 after release.
REQ-043 Scenario: preload op_count=16'hFFFE, then run 3 commands -> op_count=16'hFFFF.

Source files
------------

// File: rtl/tmng_pkg.sv
// Shared types for the tmng logic engine: opcodes and controller states.
package tmng_pkg;

  typedef enum logic [2:0] {
    OpNand = 3'd0,
    OpAnd  = 3'd1,
    OpOr   = 3'd2,
    OpNor  = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5,
    OpNota = 3'd6,
    OpLoad = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StEx   = 3'd3,
    StWb   = 3'd4
  } state_e;

endpackage

// File: rtl/tmng_regfile.sv
// DEPTH x WIDTH register file: one registered read port, one write port, async clear.
module tmng_regfile #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read samples the array before the same-edge write lands, so reads see old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
      if (we) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/tmng_engine.sv
// Multi-cycle bitwise logic engine: reads two registers, applies an opcode, writes back.
module tmng_engine
  import tmng_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_d,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  output logic              busy,
  output logic [15:0]       op_count
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] a_q, b_q, d_q;
  logic [WIDTH-1:0]  opa_q, result_q, alu_res, rd_data, res_data_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              res_valid_q, accept;
  logic [15:0]       op_count_q, op_count_d;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign rd_addr   = (state_q == StRdB) ? b_q : a_q;

  tmng_regfile #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .we     (state_q == StWb),
    .wr_addr(d_q),
    .wr_data(result_q)
  );

  // In EX the read port holds opb.
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OpNand: alu_res = ~(opa_q & rd_data);
      OpAnd:  alu_res = opa_q & rd_data;
      OpOr:   alu_res = opa_q | rd_data;
      OpNor:  alu_res = ~(opa_q | rd_data);
      OpXor:  alu_res = opa_q ^ rd_data;
      OpXnor: alu_res = ~(opa_q ^ rd_data);
      OpNota: alu_res = ~opa_q;
      OpLoad: alu_res = result_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = (cmd_op == OpLoad) ? StWb : StRdA;
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StEx;
      StEx:    state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == StWb && op_count_q != 16'hFFFF) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpNand;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      opa_q       <= '0;
      result_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= (state_q == StWb);
      op_count_q  <= op_count_d;
      if (accept) begin
        op_q     <= op_e'(cmd_op);
        a_q      <= cmd_a;
        b_q      <= cmd_b;
        d_q      <= cmd_d;
        // The immediate parks in the result register; EX overwrites it for logic ops.
        result_q <= cmd_imm;
      end
      if (state_q == StRdB) opa_q <= rd_data;
      if (state_q == StEx) result_q <= alu_res;
      if (state_q == StWb) res_data_q <= result_q;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_tmng_engine.sv
// Directed bench: a WIDTH=1 and a WIDTH=4 engine share one command bus in lockstep.
module tb_tmng_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [6:0]  cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [3:0]  imm4 = '0;
  logic        cmd_ready1, res_valid1, busy1;
  logic [0:0]  res_data1;
  logic [15:0] op_count1;
  logic        cmd_ready4, res_valid4, busy4;
  logic [3:0]  res_data4;
  logic [15:0] op_count4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tmng_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready1),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_d    (cmd_d),
    .cmd_imm  (imm4[0:0]),
    .res_valid(res_valid1),
    .res_data (res_data1),
    .busy     (busy1),
    .op_count (op_count1)
  );

  tmng_engine #(
    .WIDTH (4),
    .ADDR_W(7)
  ) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready4),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_d    (cmd_d),
    .cmd_imm  (imm4),
    .res_valid(res_valid4),
    .res_data (res_data4),
    .busy     (busy4),
    .op_count (op_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issues one command from IDLE; lat = edges from accept to res_valid (99 on timeout).
  task automatic run_cmd(input logic [2:0] op, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] d, input logic [3:0] imm, output int lat);
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d; imm4 = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (res_valid1) begin
        lat = i;
        break;
      end
    end
  endtask

  localparam logic [2:0] V_OP [6] = '{3'd4, 3'd5, 3'd3, 3'd1, 3'd0, 3'd6};
  localparam logic [6:0] V_D  [6] = '{7'd4, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13};
  localparam logic [3:0] V_E4 [6] = '{4'b0110, 4'b1001, 4'b0001, 4'b1000, 4'b0111, 4'b0011};
  localparam logic       V_E1 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int lat, acc, nbusy, rv;
    logic seen;

    repeat (3) @(negedge clk);
    check("rst_ready_held", {31'd0, cmd_ready1}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, cmd_ready1}, 32'd1);
    check("busy_after_rst", {31'd0, busy1}, 32'd0);
    check("res_data_rst", {31'd0, res_data1}, 32'd0);
    check("op_count_rst", {16'd0, op_count1}, 32'd0);
    check("r5_rst", {31'd0, dut.u_regfile.mem_q[5]}, 32'd0);

    // LOAD then OR on the loaded register.
    run_cmd(3'd7, 7'd0, 7'd0, 7'd5, 4'b0001, lat);
    check("load_lat", lat, 32'd1);
    check("load_res", {31'd0, res_data1}, 32'd1);
    run_cmd(3'd2, 7'd5, 7'd5, 7'd6, 4'b0000, lat);
    check("or_lat", lat, 32'd4);
    check("or_res", {31'd0, res_data1}, 32'd1);
    check("r6", {31'd0, dut.u_regfile.mem_q[6]}, 32'd1);
    repeat (3) @(negedge clk);
    check("res_data_hold", {31'd0, res_data1}, 32'd1);

    // NAND overwriting its own source operand.
    run_cmd(3'd7, 7'd0, 7'd0, 7'd0, 4'b0001, lat);
    run_cmd(3'd7, 7'd0, 7'd0, 7'd1, 4'b0001, lat);
    run_cmd(3'd0, 7'd0, 7'd1, 7'd0, 4'b0000, lat);
    check("nand_lat", lat, 32'd4);
    check("nand_res", {31'd0, res_data1}, 32'd0);
    check("r0_after_nand", {31'd0, dut.u_regfile.mem_q[0]}, 32'd0);

    // Wide operand table: r2=1100, r3=1010.
    run_cmd(3'd7, 7'd0, 7'd0, 7'd2, 4'b1100, lat);
    run_cmd(3'd7, 7'd0, 7'd0, 7'd3, 4'b1010, lat);
    for (int i = 0; i < 6; i++) begin
      run_cmd(V_OP[i], 7'd2, 7'd3, V_D[i], 4'b0000, lat);
      check($sformatf("op%0d_lat", V_OP[i]), lat, 32'd4);
      check($sformatf("op%0d_w4", V_OP[i]), {28'd0, res_data4}, {28'd0, V_E4[i]});
      check($sformatf("op%0d_w1", V_OP[i]), {31'd0, res_data1}, {31'd0, V_E1[i]});
    end
    check("w4_r4", {28'd0, dut4.u_regfile.mem_q[4]}, 32'h6);
    check("op_count_13", {16'd0, op_count1}, 32'd13);

    // Continuous cmd_valid: one accept per 5 cycles.
    @(negedge clk);
    cmd_op = 3'd2; cmd_a = 7'd6; cmd_b = 7'd6; cmd_d = 7'd8; imm4 = '0;
    cmd_valid = 1'b1;
    acc = 0; nbusy = 0; rv = 0;
    for (int i = 0; i < 25; i++) begin
      if (cmd_ready1) acc++;
      else nbusy++;
      @(posedge clk);
      #1;
      if (res_valid1) rv++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("stream_accepts", acc, 32'd5);
    check("stream_busy", nbusy, 32'd20);
    check("stream_results", rv, 32'd5);
    check("stream_r8", {31'd0, dut.u_regfile.mem_q[8]}, 32'd1);
    check("op_count_18", {16'd0, op_count1}, 32'd18);

    // Reset during RD_B of NAND 0,1 -> 7 (would write 1 if not aborted).
    @(negedge clk);
    cmd_op = 3'd0; cmd_a = 7'd0; cmd_b = 7'd1; cmd_d = 7'd7;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= res_valid1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= res_valid1;
    end
    check("abort_no_valid", {31'd0, seen}, 32'd0);
    check("abort_r7", {31'd0, dut.u_regfile.mem_q[7]}, 32'd0);
    check("abort_r1_clr", {31'd0, dut.u_regfile.mem_q[1]}, 32'd0);
    check("abort_op_count", {16'd0, op_count1}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready1}, 32'd1);

    // Saturation from a forced near-full count.
    force dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    check("preload", {16'd0, op_count1}, 32'h0000FFFE);
    run_cmd(3'd7, 7'd0, 7'd0, 7'd20, 4'b0001, lat);
    check("sat_first", {16'd0, op_count1}, 32'h0000FFFF);
    run_cmd(3'd7, 7'd0, 7'd0, 7'd21, 4'b0001, lat);
    run_cmd(3'd7, 7'd0, 7'd0, 7'd22, 4'b0001, lat);
    check("sat_hold", {16'd0, op_count1}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
